// File: rtl/fp32_pkg.sv
// Shared types and constants for the handshaked FP32 add/subtract unit.
package fp32_pkg;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
  } fp32_t;

  localparam logic [31:0] FP32_QNAN = 32'h7FC00000;
  localparam logic [31:0] FP32_PINF = 32'h7F800000;
  localparam int unsigned EXP_BIAS  = 127;

  // Bit positions inside o_flags = {invalid, overflow, underflow, inexact}.
  localparam int unsigned FLAG_INVALID   = 3;
  localparam int unsigned FLAG_OVERFLOW  = 2;
  localparam int unsigned FLAG_UNDERFLOW = 1;
  localparam int unsigned FLAG_INEXACT   = 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ALIGN,
    S_ADD,
    S_NORM,
    S_ROUND,
    S_DONE
  } fsm_e;

endpackage

// File: rtl/lzc28.sv
// 28-bit leading-zero counter; an all-zero input reports 28.
module lzc28 (
  input  logic [27:0] data_i,
  output logic [4:0]  cnt_o
);

  logic found;

  always_comb begin
    cnt_o = 5'd28;
    found = 1'b0;
    for (int i = 27; i >= 0; i--) begin
      if (!found && data_i[i]) begin
        cnt_o = 5'(27 - i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fp32_addsub_hs.sv
// Valid/ready FP32 adder/subtractor: one stage per FSM state, RNE rounding, FTZ/DAZ,
// fixed four-edge latency from accept to o_valid.
module fp32_addsub_hs
  import fp32_pkg::*;
#(
  parameter int unsigned SIZE_DATA = 32,
  parameter int unsigned FLAG_W    = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic                 i_alu_op,
  input  logic [SIZE_DATA-1:0] i_data_a,
  input  logic [SIZE_DATA-1:0] i_data_b,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [SIZE_DATA-1:0] o_result,
  output logic [FLAG_W-1:0]    o_flags
);

  fsm_e state_q, state_d;

  logic [31:0]       a_q, a_d, b_q, b_d;
  logic              sgn_q, sgn_d, zsgn_q, zsgn_d, sub_q, sub_d;
  logic              spec_q, spec_d, zero_q, zero_d, uf_q, uf_d;
  logic [9:0]        exp_q, exp_d;
  logic [26:0]       ma_q, ma_d, mb_q, mb_d;
  logic [27:0]       sum_q, sum_d;
  logic [31:0]       spec_res_q, spec_res_d, res_q, res_d;
  logic [FLAG_W-1:0] spec_flg_q, spec_flg_d, flags_q, flags_d;

  fp32_t       fa, fb;
  logic [26:0] ma_u, mb_u, m_big, m_sml, m_sh;
  logic [7:0]  e_big, e_sml, diff;
  logic        a_big, nan_a, nan_b, inf_a, inf_b;
  logic [4:0]  lz;
  logic [27:0] norm_sh;
  logic [26:0] norm_man;
  logic [9:0]  norm_exp, rnd_exp;
  logic        norm_zero, norm_uf, rnd_up;
  logic [24:0] rnd_man;

  assign fa = fp32_t'(a_q);
  assign fb = fp32_t'(b_q);

  lzc28 u_lzc (
    .data_i (sum_q),
    .cnt_o  (lz)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (i_valid) state_d = S_ALIGN;
      S_ALIGN: state_d = S_ADD;
      S_ADD:   state_d = S_NORM;
      S_NORM:  state_d = S_ROUND;
      S_ROUND: state_d = S_DONE;
      S_DONE:  if (i_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    o_ready = (state_q == S_IDLE);
    o_valid = (state_q == S_DONE);
  end

  // Stage arithmetic, evaluated every cycle and captured only in its own state.
  always_comb begin
    nan_a = (&fa.exp) && (|fa.frac);
    nan_b = (&fb.exp) && (|fb.frac);
    inf_a = (&fa.exp) && !(|fa.frac);
    inf_b = (&fb.exp) && !(|fb.frac);
    ma_u  = (fa.exp == 8'd0) ? 27'd0 : {1'b1, fa.frac, 3'b000};
    mb_u  = (fb.exp == 8'd0) ? 27'd0 : {1'b1, fb.frac, 3'b000};
    a_big = {fa.exp, ma_u} >= {fb.exp, mb_u};
    e_big = a_big ? fa.exp : fb.exp;
    e_sml = a_big ? fb.exp : fa.exp;
    m_big = a_big ? ma_u : mb_u;
    m_sml = a_big ? mb_u : ma_u;
    diff  = e_big - e_sml;
    if (diff >= 8'd26) m_sh = {26'd0, |m_sml};
    else m_sh = (m_sml >> diff) | {26'd0, |(m_sml & ~(27'h7FFFFFF << diff))};

    spec_res_d = FP32_QNAN;
    spec_flg_d = '0;
    if (nan_a || nan_b) begin
      spec_flg_d[FLAG_INVALID] = (nan_a && !fa.frac[22]) || (nan_b && !fb.frac[22]);
    end else if (inf_a && inf_b && (fa.sign != fb.sign)) begin
      spec_flg_d[FLAG_INVALID] = 1'b1;
    end else if (inf_a) begin
      spec_res_d = {fa.sign, FP32_PINF[30:0]};
    end else if (inf_b) begin
      spec_res_d = {fb.sign, FP32_PINF[30:0]};
    end

    // lz counts over 28 bits, so the carry column makes the normal position lz == 1.
    norm_sh = sum_q << (lz - 5'd1);
    if (sum_q[27]) begin
      norm_man = {sum_q[27:2], |sum_q[1:0]};
      norm_exp = exp_q + 10'd1;
    end else begin
      norm_man = norm_sh[26:0];
      norm_exp = exp_q - {5'd0, lz} + 10'd1;
    end
    norm_zero = (sum_q == 28'd0);
    norm_uf   = !norm_zero && (norm_exp[9] || norm_exp == 10'd0);

    rnd_up  = ma_q[2] && (ma_q[1] || ma_q[0] || ma_q[3]);
    rnd_man = {1'b0, ma_q[26:3]} + {24'd0, rnd_up};
    rnd_exp = exp_q + {9'd0, rnd_man[24]};
  end

  always_comb begin
    a_d = a_q;  b_d = b_q;  sgn_d = sgn_q;  zsgn_d = zsgn_q;  sub_d = sub_q;
    spec_d = spec_q;  zero_d = zero_q;  uf_d = uf_q;  exp_d = exp_q;
    ma_d = ma_q;  mb_d = mb_q;  sum_d = sum_q;  res_d = res_q;  flags_d = flags_q;
    case (state_q)
      S_IDLE: if (i_valid) begin
        a_d = i_data_a;
        b_d = {i_data_b[31] ^ i_alu_op, i_data_b[30:0]};
      end
      S_ALIGN: begin
        sgn_d  = a_big ? fa.sign : fb.sign;
        zsgn_d = fa.sign & fb.sign;
        sub_d  = fa.sign ^ fb.sign;
        exp_d  = {2'b00, e_big};
        ma_d   = m_big;
        mb_d   = m_sh;
        spec_d = nan_a || nan_b || inf_a || inf_b;
      end
      S_ADD: sum_d = sub_q ? ({1'b0, ma_q} - {1'b0, mb_q}) : ({1'b0, ma_q} + {1'b0, mb_q});
      S_NORM: begin
        ma_d   = norm_man;
        exp_d  = norm_exp;
        zero_d = norm_zero || norm_uf;
        uf_d   = norm_uf;
        sgn_d  = norm_zero ? zsgn_q : sgn_q;
      end
      S_ROUND: begin
        flags_d = '0;
        if (spec_q) begin
          res_d   = spec_res_q;
          flags_d = spec_flg_q;
        end else if (zero_q) begin
          res_d = {sgn_q, 31'd0};
          flags_d[FLAG_UNDERFLOW] = uf_q;
          flags_d[FLAG_INEXACT]   = uf_q;
        end else if (rnd_exp >= 10'd255) begin
          res_d = {sgn_q, FP32_PINF[30:0]};
          flags_d[FLAG_OVERFLOW] = 1'b1;
          flags_d[FLAG_INEXACT]  = 1'b1;
        end else begin
          res_d = {sgn_q, rnd_exp[7:0], rnd_man[22:0]};
          flags_d[FLAG_INEXACT] = |ma_q[2:0];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      a_q <= '0;  b_q <= '0;  sgn_q <= 1'b0;  zsgn_q <= 1'b0;  sub_q <= 1'b0;
      spec_q <= 1'b0;  zero_q <= 1'b0;  uf_q <= 1'b0;  exp_q <= '0;
      ma_q <= '0;  mb_q <= '0;  sum_q <= '0;  spec_res_q <= '0;  spec_flg_q <= '0;
      res_q <= '0;  flags_q <= '0;
    end else begin
      a_q <= a_d;  b_q <= b_d;  sgn_q <= sgn_d;  zsgn_q <= zsgn_d;  sub_q <= sub_d;
      spec_q <= spec_d;  zero_q <= zero_d;  uf_q <= uf_d;  exp_q <= exp_d;
      ma_q <= ma_d;  mb_q <= mb_d;  sum_q <= sum_d;  spec_res_q <= spec_res_d;
      spec_flg_q <= spec_flg_d;  res_q <= res_d;  flags_q <= flags_d;
    end
  end

  assign o_result = res_q;
  assign o_flags  = flags_q;

endmodule

// File: tb/tb_fp32_addsub_hs.sv
// Bench for fp32_addsub_hs: directed corner cases, handshake/reset behaviour and random
// operands checked against a real-arithmetic reference model.
module tb_fp32_addsub_hs;
  import fp32_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_valid = 1'b0;
  logic        i_alu_op = 1'b0;
  logic        i_ready = 1'b1;
  logic [31:0] i_data_a = '0;
  logic [31:0] i_data_b = '0;
  logic        o_ready, o_valid;
  logic [31:0] o_result;
  logic [3:0]  o_flags;

  int checks = 0;
  int errors = 0;

  fp32_addsub_hs #(
    .SIZE_DATA (32),
    .FLAG_W    (4)
  ) dut (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_alu_op (i_alu_op),
    .i_data_a (i_data_a),
    .i_data_b (i_data_b),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_result (o_result),
    .o_flags  (o_flags)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // FP32 (with DAZ) to exact double.
  function automatic real to_real(input logic [31:0] x);
    logic [63:0] d;
    if (x[30:23] == 8'd0) return 0.0;
    d = {x[31], 11'(x[30:23]) + 11'(1023 - EXP_BIAS), x[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  // Returns {flags, result}. Operands are assumed close enough that the double sum is exact.
  function automatic logic [35:0] fp_ref(input logic [31:0] a, input logic [31:0] bin,
                                         input logic op);
    logic [31:0] b;
    logic        a_nan, b_nan, a_inf, b_inf, up, inx;
    logic [63:0] d;
    logic [52:0] m;
    logic [24:0] m25;
    real         r;
    int          e;
    b     = {bin[31] ^ op, bin[30:0]};
    a_nan = (a[30:23] == 8'hFF) && (a[22:0] != 0);
    b_nan = (b[30:23] == 8'hFF) && (b[22:0] != 0);
    a_inf = (a[30:23] == 8'hFF) && (a[22:0] == 0);
    b_inf = (b[30:23] == 8'hFF) && (b[22:0] == 0);
    if (a_nan || b_nan) return {(a_nan && !a[22]) || (b_nan && !b[22]), 3'b000, FP32_QNAN};
    if (a_inf && b_inf && (a[31] != b[31])) return {4'b1000, FP32_QNAN};
    if (a_inf) return {4'b0000, a};
    if (b_inf) return {4'b0000, b};
    r = to_real(a) + to_real(b);
    if (r == 0.0)
      return {4'b0000, (a[30:23] == 0) && (b[30:23] == 0) && a[31] && b[31], 31'd0};
    d   = $realtobits(r);
    e   = int'(d[62:52]) - int'(1023 - EXP_BIAS);
    m   = {1'b1, d[51:0]};
    inx = (m[28:0] != 0);
    if (e <= 0) return {4'b0011, d[63], 31'd0};
    up  = m[28] && ((m[27:0] != 0) || m[29]);
    m25 = {1'b0, m[52:29]} + 25'(up);
    if (m25[24]) e++;
    if (e >= 255) return {4'b0101, d[63], 31'h7F800000};
    return {3'b000, inx, d[63], 8'(e), m25[22:0]};
  endfunction

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic op, input logic [31:0] er, input logic [3:0] ef);
    int n;
    @(negedge i_clk);
    i_valid = 1'b1;  i_data_a = a;  i_data_b = b;  i_alu_op = op;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    n = 0;
    while (!o_valid && n < 10) begin
      @(posedge i_clk); #1;
      n++;
    end
    chk({tag, "/latency"}, 32'(n), 32'd4);
    chk({tag, "/result"}, o_result, er);
    chk({tag, "/flags"}, {28'd0, o_flags}, {28'd0, ef});
    if (i_ready) begin
      @(posedge i_clk); #1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [31:0] ra, rb;
    logic        rop;
    logic [35:0] exp_v;
    int          ea, eb;

    repeat (2) @(posedge i_clk);
    #1;
    chk("reset/ready", {31'd0, o_ready}, 32'd1);
    chk("reset/valid", {31'd0, o_valid}, 32'd0);
    chk("reset/result", o_result, 32'd0);
    chk("reset/flags", {28'd0, o_flags}, 32'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    run_op("add_1_2", 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000);
    run_op("cancel", 32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'b0000);
    run_op("negzero", 32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0000);
    run_op("rne_tie", 32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001);
    run_op("overflow", 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0101);
    run_op("inf_m_inf", 32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 4'b1000);
    run_op("snan", 32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b1000);
    run_op("qnan", 32'h3F800000, 32'h7FC00001, 1'b1, 32'h7FC00000, 4'b0000);
    run_op("inf_p_1", 32'h3F800000, 32'hFF800000, 1'b0, 32'hFF800000, 4'b0000);
    run_op("underflow", 32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 4'b0011);
    run_op("daz", 32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 4'b0000);
    run_op("far_sticky", 32'h3F800000, 32'h0D800000, 1'b1, 32'h3F800000, 4'b0001);

    // Backpressure: result held, new operands ignored while DONE.
    i_ready = 1'b0;
    run_op("bp_op", 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000);
    @(negedge i_clk);
    i_valid = 1'b1;  i_data_a = 32'h40A00000;  i_data_b = 32'h40A00000;
    for (int k = 0; k < 3; k++) begin
      @(posedge i_clk); #1;
      chk("bp/hold_result", o_result, 32'h40400000);
      chk("bp/ready_low", {31'd0, o_ready}, 32'd0);
      chk("bp/valid_high", {31'd0, o_valid}, 32'd1);
    end
    @(negedge i_clk);
    i_valid = 1'b0;  i_ready = 1'b1;
    @(posedge i_clk); #1;
    chk("bp/back_idle", {31'd0, o_ready}, 32'd1);
    repeat (6) @(posedge i_clk);
    #1;
    chk("bp/no_ghost_op", {31'd0, o_valid}, 32'd0);

    // Reset while in S_ADD aborts the operation.
    @(negedge i_clk);
    i_valid = 1'b1;  i_data_a = 32'h3F800000;  i_data_b = 32'h40000000;  i_alu_op = 1'b0;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    @(posedge i_clk); #1;
    @(negedge i_clk);
    i_rst_n = 1'b0;
    #1;
    chk("rst_mid/valid", {31'd0, o_valid}, 32'd0);
    chk("rst_mid/ready", {31'd0, o_ready}, 32'd1);
    chk("rst_mid/result", o_result, 32'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    repeat (6) @(posedge i_clk);
    #1;
    chk("rst_mid/no_result", {31'd0, o_valid}, 32'd0);
    run_op("after_rst", 32'h40000000, 32'h3F800000, 1'b1, 32'h3F800000, 4'b0000);

    for (int k = 0; k < 60; k++) begin
      ea = int'($urandom_range(1, 254));
      eb = ea + int'($urandom_range(0, 50)) - 25;
      if (eb < 1) eb = 1;
      if (eb > 254) eb = 254;
      if ($urandom_range(0, 7) == 0) eb = 0;
      if ($urandom_range(0, 5) == 0) eb = ea;
      ra  = {1'($urandom), 8'(ea), 23'($urandom)};
      rb  = {1'($urandom), 8'(eb), 23'($urandom)};
      rop = 1'($urandom);
      exp_v = fp_ref(ra, rb, rop);
      run_op($sformatf("rand%0d", k), ra, rb, rop, exp_v[31:0], exp_v[35:32]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
